// File: rtl/axis_patgen_pkg.sv
// axis_patgen_pkg: shared types and constants for the AXI4-Stream pattern
// generator (axis_pattern_gen) and its LFSR sub-module.
//   mode_e    : data pattern selector (counter, LFSR, walking-one, alternating)
//   state_e   : control FSM states
//   LFSR_TAPS : tap mask for the 32-bit Fibonacci LFSR (taps 32,22,2,1)
//   ALT_EVEN / ALT_ODD : byte values of the alternating pattern
package axis_patgen_pkg;

  typedef enum logic [1:0] {
    MODE_CNT  = 2'd0,
    MODE_LFSR = 2'd1,
    MODE_WALK = 2'd2,
    MODE_ALT  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Taps 32,22,2,1 expressed as bit positions 31,21,1,0.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam logic [7:0] ALT_EVEN = 8'h55;
  localparam logic [7:0] ALT_ODD  = 8'hAA;

  // One Fibonacci step: shift left, feedback (XOR of tapped bits) enters bit 0.
  function automatic logic [31:0] lfsr_step(input logic [31:0] q);
    return {q[30:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/axis_patgen_lfsr.sv
// axis_patgen_lfsr: 32-bit Fibonacci LFSR (taps 32,22,2,1).
// Ports:
//   clk, rst_L : clock, asynchronous active-low reset (state reset to SEED)
//   load       : reload SEED (has priority over step)
//   step       : advance one state
//   lfsr_next  : the state the register will take on the next step
// The current state itself is not exported: the top level already holds the
// current word in its tdata register and only needs the successor.
module axis_patgen_lfsr
  import axis_patgen_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        load,
  input  logic        step,
  output logic [31:0] lfsr_next
);

  logic [31:0] lfsr_q;

  assign lfsr_next = lfsr_step(lfsr_q);

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      lfsr_q <= SEED;
    end else if (load) begin
      lfsr_q <= SEED;
    end else if (step) begin
      lfsr_q <= lfsr_next;
    end
  end

endmodule

// File: rtl/axis_pattern_gen.sv
// axis_pattern_gen: parametrised AXI4-Stream pattern source.
// Emits cfg_num_pkts packets (0 = until stop) of cfg_pkt_len beats (0 = 1)
// in one of four patterns: counter, LFSR, walking-one, alternating 55/AA.
// Ports:
//   clk, rst_L                 : clock, asynchronous active-low reset
//   cfg_mode/pkt_len/num_pkts  : run configuration, sampled on an accepted start
//   start, stop                : one-cycle control pulses
//   busy, done                 : run status; done pulses once per completed run
//   m_axis_*                   : AXI4-Stream master (tkeep is constant all ones)
//   state_dbg                  : current FSM state (state_e encoding)
// Optional build macro AXIS_PATGEN_TUSER_EN adds m_axis_tuser, high on the
// first beat of every packet.
//
// Handshake: a beat transfers on a cycle where m_axis_tvalid & m_axis_tready
// are both high at the clock edge. Once tvalid is raised, tvalid, tdata, tlast
// (and tuser) hold their values until that transfer; tvalid never drops inside
// a packet.
module axis_pattern_gen
  import axis_patgen_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int          LEN_WIDTH  = 16,
  parameter logic [31:0] LFSR_SEED  = 32'h0000_0001
) (
  input  logic                  clk,
  input  logic                  rst_L,
  input  logic [1:0]            cfg_mode,
  input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
  input  logic [LEN_WIDTH-1:0]  cfg_num_pkts,
  input  logic                  start,
  input  logic                  stop,
  output logic                  busy,
  output logic                  done,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
`ifdef AXIS_PATGEN_TUSER_EN
  output logic                  m_axis_tuser,
`endif
  output logic                  m_axis_tlast,
  output logic [1:0]            state_dbg
);

  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;
  localparam logic [DATA_WIDTH-1:0] DATA_ONE = 1;

  // Spread the 32-bit LFSR word over the data bus (truncated when narrower).
  function automatic logic [DATA_WIDTH-1:0] rep32(input logic [31:0] w);
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < DATA_WIDTH; i++) r[i] = w[i % 32];
    return r;
  endfunction

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [LEN_WIDTH-1:0]  len_m1_q, len_m1_d;
  logic [LEN_WIDTH-1:0]  num_q, num_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [LEN_WIDTH-1:0]  pkt_q, pkt_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [31:0]           lfsr_next;
  logic [DATA_WIDTH-1:0] first_word;
  logic [DATA_WIDTH-1:0] next_word;
  logic                  accept_start;
  logic                  fire;
  logic                  last_pkt;
  logic                  run_end;

  assign accept_start = (state_q == IDLE) && start;
  assign fire         = (state_q != IDLE) && tvalid_q && m_axis_tready;
  // Only a finite run has a final packet; the saturating counter of an
  // infinite run can never satisfy this because num_q is zero.
  assign last_pkt     = (num_q != '0) && (pkt_q == num_q - LEN_ONE);
  // The run ends on the tlast transfer if it is the final packet, if a stop
  // was seen earlier (FINISH) or if stop arrives in this very cycle.
  assign run_end      = fire && tlast_q &&
                        ((state_q == FINISH) || stop || last_pkt);

  axis_patgen_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk       (clk),
    .rst_L     (rst_L),
    .load      (accept_start),
    .step      (fire && (mode_q == MODE_LFSR)),
    .lfsr_next (lfsr_next)
  );

  always_comb begin
    first_word = '0;
    case (mode_e'(cfg_mode))
      MODE_CNT:  first_word = '0;
      MODE_LFSR: first_word = rep32(LFSR_SEED);
      MODE_WALK: first_word = DATA_ONE;
      MODE_ALT:  first_word = {KEEP_WIDTH{ALT_EVEN}};
      default:   first_word = '0;
    endcase
  end

  // Every pattern's successor is a pure function of the word on the bus.
  always_comb begin
    next_word = tdata_q;
    case (mode_q)
      MODE_CNT:  next_word = tdata_q + DATA_ONE;
      MODE_LFSR: next_word = rep32(lfsr_next);
      MODE_WALK: next_word = {tdata_q[DATA_WIDTH-2:0], tdata_q[DATA_WIDTH-1]};
      MODE_ALT:  next_word = (tdata_q[7:0] == ALT_EVEN) ? {KEEP_WIDTH{ALT_ODD}}
                                                        : {KEEP_WIDTH{ALT_EVEN}};
      default:   next_word = tdata_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    len_m1_d = len_m1_q;
    num_d    = num_q;
    beat_d   = beat_q;
    pkt_d    = pkt_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          mode_d   = mode_e'(cfg_mode);
          len_m1_d = (cfg_pkt_len == '0) ? '0 : cfg_pkt_len - LEN_ONE;
          num_d    = cfg_num_pkts;
          beat_d   = '0;
          pkt_d    = '0;
          tvalid_d = 1'b1;
          tlast_d  = (cfg_pkt_len <= LEN_ONE);
          tdata_d  = first_word;
          busy_d   = 1'b1;
        end
      end
      RUN, FINISH: begin
        if ((state_q == RUN) && stop) state_d = FINISH;
        if (fire) begin
          tdata_d = next_word;
          if (tlast_q) begin
            beat_d  = '0;
            pkt_d   = (pkt_q == '1) ? pkt_q : pkt_q + LEN_ONE;
            tlast_d = (len_m1_q == '0);
          end else begin
            beat_d  = beat_q + LEN_ONE;
            tlast_d = ((beat_q + LEN_ONE) == len_m1_q);
          end
          if (run_end) begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q  <= IDLE;
      mode_q   <= MODE_CNT;
      len_m1_q <= '0;
      num_q    <= '0;
      beat_q   <= '0;
      pkt_q    <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      len_m1_q <= len_m1_d;
      num_q    <= num_d;
      beat_q   <= beat_d;
      pkt_q    <= pkt_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef AXIS_PATGEN_TUSER_EN
  logic tuser_q, tuser_d;

  // The beat after a tlast transfer opens a new packet.
  always_comb begin
    tuser_d = tuser_q;
    if (accept_start)  tuser_d = 1'b1;
    else if (run_end)  tuser_d = 1'b0;
    else if (fire)     tuser_d = tlast_q;
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) tuser_q <= 1'b0;
    else        tuser_q <= tuser_d;
  end

  assign m_axis_tuser = tuser_q;
`endif

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = '1;
  assign m_axis_tlast  = tlast_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign state_dbg     = state_q;

endmodule
